mole_round_controller: RTL and testbench



---
 rtl/mole_round_controller_if.sv | 25 ++
 rtl/mole_round_controller.sv | 123 ++++++++++++
 tb/tb_mole_round_controller.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mole_round_controller_if.sv
// Round-engine signal bundle: game/hit/speed/gap in from the front end, mole/score/misses/round_done out to the displays.
interface mole_round_controller_if #(
  parameter int N_MOLES = 3,
  parameter int CNT_W   = 28,
  parameter int SCORE_W = 8
);
  logic               game;
  logic [N_MOLES-1:0] hit;
  logic [CNT_W-1:0]   speed;
  logic [CNT_W-1:0]   gap;
  logic [N_MOLES-1:0] mole;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] misses;
  logic               round_done;

  modport master (
    output game, hit, speed, gap,
    input  mole, score, misses, round_done
  );

  modport slave (
    input  game, hit, speed, gap,
    output mole, score, misses, round_done
  );
endinterface

// File: rtl/mole_round_controller.sv
// Whack-a-mole round engine (IDLE/GAP/SELECT/UP), LFSR mole pick, saturating hit/miss scoring; all outputs registered, 1-cycle hit latency.
// Optional MOLE_MISS_PENALTY_EN: a wrong-button pulse during UP decrements score (floor 0).
module mole_round_controller #(
  parameter int N_MOLES = 3,
  parameter int CNT_W   = 28,
  parameter int SCORE_W = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  mole_round_controller_if.slave        bus
);
  localparam int IDX_W = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GAP    = 2'd1;
  localparam logic [1:0] SELECT = 2'd2;
  localparam logic [1:0] UP     = 2'd3;

  localparam logic [15:0]        LFSR_SEED = 16'hACE1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [N_MOLES-1:0] MOLE_ONE  = {{(N_MOLES-1){1'b0}}, 1'b1};

  logic [1:0]         state;
  logic [CNT_W-1:0]   timer;
  logic [15:0]        lfsr;
  logic [IDX_W-1:0]   idx;
  logic [N_MOLES-1:0] mole_q;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] misses_q;
  logic               done_q;

  logic [IDX_W-1:0]   cand;
  logic               cand_ok;
  logic               lfsr_fb;
  logic [N_MOLES-1:0] cand_mask;
  logic [N_MOLES-1:0] idx_mask;
  logic               hit_ok;
  logic               wrong_hit;

  // Fibonacci taps 16,14,13,11; a non-zero seed never reaches the all-zero lock-up state.
  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign cand      = lfsr[IDX_W-1:0];
  assign cand_ok   = (int'(cand) < N_MOLES);
  assign cand_mask = MOLE_ONE << cand;
  assign idx_mask  = MOLE_ONE << idx;
  assign hit_ok    = |(bus.hit & idx_mask);
  assign wrong_hit = |(bus.hit & ~idx_mask);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      lfsr     <= LFSR_SEED;
      idx      <= '0;
      mole_q   <= '0;
      score_q  <= '0;
      misses_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!bus.game) begin
        // score/misses are held so the final result stays on the display
        state  <= IDLE;
        mole_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            mole_q   <= '0;
            score_q  <= '0;
            misses_q <= '0;
            timer    <= bus.gap;
            state    <= GAP;
          end
          GAP: begin
            mole_q <= '0;
            if (timer == '0) state <= SELECT;
            else             timer <= timer - CNT_ONE;
          end
          SELECT: begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            if (cand_ok) begin
              idx    <= cand;
              mole_q <= cand_mask;
              timer  <= bus.speed;
              state  <= UP;
            end
          end
          UP: begin
            // a correct hit on the timeout cycle still scores as a hit
            if (hit_ok || timer == '0) begin
              if (hit_ok) begin
                if (score_q != SCORE_MAX) score_q <= score_q + SCORE_ONE;
              end else if (misses_q != SCORE_MAX) begin
                misses_q <= misses_q + SCORE_ONE;
              end
              done_q <= 1'b1;
              mole_q <= '0;
              timer  <= bus.gap;
              state  <= GAP;
            end else begin
              timer <= timer - CNT_ONE;
            end
`ifdef MOLE_MISS_PENALTY_EN
            if (!hit_ok && wrong_hit && score_q != '0) score_q <= score_q - SCORE_ONE;
`endif
          end
        endcase
      end
    end
  end

`ifndef MOLE_MISS_PENALTY_EN
  logic unused_wrong;
  assign unused_wrong = wrong_hit;
`endif

  assign bus.mole       = mole_q;
  assign bus.score      = score_q;
  assign bus.misses     = misses_q;
  assign bus.round_done = done_q;
endmodule

// File: tb/tb_mole_round_controller.sv
// Round-level randomized bench for mole_round_controller against a per-round timing/score model.
module tb_mole_round_controller;
  localparam int N    = 3;
  localparam int CW   = 28;
  localparam int SW   = 8;
  localparam int IW   = $clog2(N);
  localparam int SMAX = (1 << SW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [15:0] lfsr_m = 16'hACE1;
  int exp_score  = 0;
  int exp_misses = 0;
  int gap_lo = 2, gap_hi = 2, spd_lo = 4, spd_hi = 4;
  bit wrong_en = 1'b0;

  always #5 clock = ~clock;

  mole_round_controller_if #(.N_MOLES(N), .CNT_W(CW), .SCORE_W(SW)) bus ();

  mole_round_controller #(.N_MOLES(N), .CNT_W(CW), .SCORE_W(SW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic obs(input string where, input int m, input int d);
    check({where, ".mole"},   32'(bus.mole),       m);
    check({where, ".done"},   32'(bus.round_done), d);
    check({where, ".score"},  32'(bus.score),      exp_score);
    check({where, ".misses"}, 32'(bus.misses),     exp_misses);
  endtask

  // Entry: looking at the first GAP cycle of a round. Exit: looking at the cycle after the round ended.
  task automatic play_round(input bit first, input int hit_in, input int wrong, input int abort_in);
    int n, idx, blank, spd, hit_j, abort_j, mexp, w;
    n = 0;
    do begin
      idx    = int'(lfsr_m[IW-1:0]);
      lfsr_m = lfsr_next(lfsr_m);
      n++;
    end while (idx >= N);
    blank     = int'(bus.gap) + 1 + n;
    spd       = $urandom_range(spd_hi, spd_lo);
    bus.speed = CW'(spd);
    bus.gap   = CW'($urandom_range(gap_hi, gap_lo));
    hit_j     = (hit_in > spd) ? spd : hit_in;
    abort_j   = (abort_in > spd) ? spd : abort_in;
    mexp      = 1 << idx;

    for (int i = 0; i < blank; i++) begin
      if (i > 0 || first) obs("blank", 0, 0);
      if ($urandom_range(0, 3) == 0) bus.hit = N'($urandom_range(1, (1 << N) - 1));
      step();
      bus.hit = '0;
    end

    for (int j = 0; j <= spd; j++) begin
      obs("up", mexp, 0);
      if (j == 1) bus.speed = CW'($urandom);
      if (j == abort_j) begin
        bus.game = 1'b0;
        step();
        obs("abort", 0, 0);
        return;
      end
      if (j == hit_j) begin
        bus.hit = N'(mexp | wrong);
        step();
        bus.hit = '0;
        exp_score = (exp_score == SMAX) ? SMAX : exp_score + 1;
        obs("hit", 0, 1);
        return;
      end
      if (j == spd) begin
        step();
        exp_misses = (exp_misses == SMAX) ? SMAX : exp_misses + 1;
        obs("timeout", 0, 1);
        return;
      end
      if (wrong_en && $urandom_range(0, 2) == 0) begin
        w = $urandom_range(1, (1 << N) - 1) & ~mexp;
        bus.hit = N'(w);
`ifdef MOLE_MISS_PENALTY_EN
        if (w != 0 && exp_score > 0) exp_score--;
`endif
      end
      step();
      bus.hit = '0;
    end
  endtask

  initial begin
    bus.game  = 1'b0;
    bus.hit   = '0;
    bus.speed = CW'(4);
    bus.gap   = CW'(2);

    #1 reset = 1'b1;
    #2 obs("reset", 0, 0);
    step();
    step();
    obs("reset_hold", 0, 0);
    reset = 1'b0;
    step();
    obs("idle", 0, 0);

    // Fixed gap=2 speed=4: first mole must be index 1, then timeout, hit, and wrong+correct hit.
    bus.game = 1'b1;
    step();
    play_round(1'b1, -1, 0, -1);
    play_round(1'b0, 2, 0, -1);
    play_round(1'b0, 1, 3'b111, -1);

    gap_lo = 0; gap_hi = 3; spd_lo = 0; spd_hi = 5;
    wrong_en = 1'b1;
    repeat (40)
      play_round(1'b0, ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 6),
                 $urandom_range(0, 7), -1);

    // Abort mid-UP: score held while idle, cleared when the game restarts.
    play_round(1'b0, -1, 0, $urandom_range(0, 5));
    step();
    obs("idle_hold", 0, 0);
    bus.game   = 1'b1;
    exp_score  = 0;
    exp_misses = 0;
    step();
    play_round(1'b1, 0, 0, -1);
    play_round(1'b0, -1, 0, -1);

    // Reset mid-round re-seeds the LFSR.
    repeat ($urandom_range(1, 8)) step();
    reset = 1'b1;
    #1;
    exp_score  = 0;
    exp_misses = 0;
    lfsr_m     = 16'hACE1;
    obs("reset_mid", 0, 0);
    step();
    reset = 1'b0;
    step();
    play_round(1'b1, -1, 0, -1);

    // Saturation of score, then misses.
    wrong_en = 1'b0;
    gap_lo = 0; gap_hi = 0; spd_lo = 0; spd_hi = 1;
    repeat (260) play_round(1'b0, 0, 0, -1);
    repeat (260) play_round(1'b0, -1, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
